mem_32x8: RTL and testbench

MEM_32X8 -- requirements
Module: mem_32x8

---
 rtl/mem_32x8.sv | 34 +++
 tb/tb_mem_32x8.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_32x8.sv
// Flip-flop word memory: one access per cycle. Reads return on dout one cycle after the address edge.
// No backpressure: en is sampled every rising edge. Writes leave dout untouched.
module mem_32x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage and read register share one async-cleared process, so a reset clears both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '{default: '0};
            dout <= '0;
        end else if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_mem_32x8.sv
// Self-checking bench for mem_32x8: directed vector table, sweep, random traffic and async reset.
module tb_mem_32x8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       we;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    int n_vec;
    int n_err;

    logic [7:0] ref_mem [32];
    logic [7:0] ref_dout;

    typedef struct {
        logic       en;
        logic       we;
        logic [4:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [15];

    mem_32x8 #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dout=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle 1ns before anything is sampled or driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour: array of words plus the last read result.
    task automatic ref_access(input logic e, input logic w, input logic [4:0] a, input logic [7:0] d);
        if (e) begin
            if (w) ref_mem[a] = d;
            else   ref_dout = ref_mem[a];
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        ref_dout = 8'h00;
    endtask

    task automatic drive(input logic e, input logic w, input logic [4:0] a, input logic [7:0] d);
        en   = e;
        we   = w;
        addr = a;
        din  = d;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ref_reset();

        vecs[0]  = '{1'b1, 1'b1, 5'd0,  8'hAA, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 5'd1,  8'h55, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 5'd0,  8'h00, 8'hAA};
        vecs[3]  = '{1'b1, 1'b0, 5'd1,  8'h00, 8'h55};
        vecs[4]  = '{1'b1, 1'b1, 5'd5,  8'hC3, 8'h55};
        vecs[5]  = '{1'b1, 1'b0, 5'd5,  8'h00, 8'hC3};
        vecs[6]  = '{1'b1, 1'b1, 5'd5,  8'h3C, 8'hC3};
        vecs[7]  = '{1'b1, 1'b0, 5'd5,  8'h00, 8'h3C};
        vecs[8]  = '{1'b1, 1'b1, 5'd3,  8'h11, 8'h3C};
        vecs[9]  = '{1'b0, 1'b1, 5'd3,  8'hFF, 8'h3C};
        vecs[10] = '{1'b1, 1'b0, 5'd3,  8'h00, 8'h11};
        vecs[11] = '{1'b0, 1'b0, 5'd1,  8'h00, 8'h11};
        vecs[12] = '{1'b1, 1'b0, 5'd31, 8'h00, 8'h00};
        vecs[13] = '{1'b1, 1'b1, 5'd31, 8'h7E, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 5'd31, 8'h00, 8'h7E};

        // Reset state
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 5'd4, 8'h77);
        #1;
        chk("reset_dout", dout, 8'h00);
        step();
        chk("reset_blocks_access", dout, 8'h00);
        #3 rst_n = 1'b1;
        drive(1'b1, 1'b0, 5'd4, 8'h00);
        step();
        chk("no_write_during_reset", dout, 8'h00);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].din);
            ref_access(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].din);
            step();
            chk($sformatf("table[%0d]", i), dout, vecs[i].exp);
        end

        // Descending sweep: write i to i, then read back one cycle after each address
        for (int i = 31; i >= 0; i--) begin
            drive(1'b1, 1'b1, 5'(i), 8'(i));
            ref_access(1'b1, 1'b1, 5'(i), 8'(i));
            step();
        end
        for (int i = 31; i >= 0; i--) begin
            drive(1'b1, 1'b0, 5'(i), 8'h00);
            ref_access(1'b1, 1'b0, 5'(i), 8'h00);
            step();
            chk($sformatf("sweep[%0d]", i), dout, 8'(i));
        end

        // Random traffic against the reference array
        for (int i = 0; i < 400; i++) begin
            logic       e;
            logic       w;
            logic [4:0] a;
            logic [7:0] d;
            e = ($urandom_range(0, 9) != 0);
            w = $urandom_range(0, 1) == 1;
            a = 5'($urandom_range(0, 31));
            d = 8'($urandom);
            drive(e, w, a, d);
            ref_access(e, w, a, d);
            step();
            chk("random", dout, ref_dout);
        end

        // Write then immediate read of the same word, leaving dout non-zero before reset
        drive(1'b1, 1'b1, 5'd9, 8'hA5);
        step();
        drive(1'b1, 1'b0, 5'd9, 8'h00);
        step();
        chk("wr_then_rd", dout, 8'hA5);

        // Reset asserted mid-cycle with a write pending: dout clears before any clock edge
        drive(1'b1, 1'b1, 5'd7, 8'h99);
        #3 rst_n = 1'b0;
        ref_reset();
        #1;
        chk("async_reset_dout", dout, 8'h00);
        step();
        chk("reset_held_dout", dout, 8'h00);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'(i), 8'h00);
            step();
            chk($sformatf("post_reset_rd[%0d]", i), dout, 8'h00);
        end

        // First access after reset release takes effect immediately
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        drive(1'b1, 1'b1, 5'd2, 8'h5A);
        step();
        drive(1'b1, 1'b0, 5'd2, 8'h00);
        step();
        chk("first_access_after_reset", dout, 8'h5A);
        drive(1'b1, 1'b0, 5'd7, 8'h00);
        step();
        chk("aborted_write_absent", dout, 8'h00);

        drive(1'b0, 1'b0, 5'd0, 8'h00);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
